// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FWFT fifo write port among N producers; also sequences a one-cycle sync flush between bursts.
// One arbitration cycle per grant, then the owner's words pass through combinationally; fifo_full stalls the owner in place.
module fifo_wr_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    input  logic [N-1:0]         last,
    output logic [N-1:0]         ack,
    output logic                 fifo_w,
    output logic [WIDTH-1:0]     fifo_din,
    input  logic                 fifo_full,
    output logic                 fifo_clr,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int OW = $clog2(N);
    localparam int CW = $clog2(BURST) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_vld;
    logic [OW-1:0] pick_idx;
    logic          req_own;
    logic          last_own;
    logic          wr;
    logic [OW-1:0] nxt_ptr;

    // Scan downwards so the requester closest to rr_ptr is the last to overwrite the pick.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = OW'(idx);
            end
        end
    end

    assign req_own  = req[owner_q];
    assign last_own = last[owner_q];
    assign wr       = (state_q == S_OWN) && req_own && !fifo_full;
    assign nxt_ptr  = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;

    always_comb begin
        ack          = '0;
        ack[owner_q] = wr;
    end

    assign fifo_w     = wr;
    assign fifo_din   = data[int'(owner_q)*WIDTH +: WIDTH];
    assign fifo_clr   = (state_q == S_FLUSH);
    assign flush_done = (state_q == S_FLUSH);
    assign busy       = (state_q != S_IDLE);
    assign owner      = owner_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                end else if (pick_vld) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (!req_own) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = nxt_ptr;
                end else if (wr) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BURST - 1) || last_own) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = nxt_ptr;
                    end
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: counter-driven producers, a queue standing in for the shared fifo.
module tb_fifo_wr_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   ack;
    logic           fifo_w;
    logic [W-1:0]   fifo_din;
    logic           fifo_full;
    logic           fifo_clr;
    logic           flush_req;
    logic           flush_done;
    logic           busy;
    logic [1:0]     owner;

    fifo_wr_arb #(.N(N), .WIDTH(W), .BURST(4)) dut (
        .clk(clk), .rstn(rstn), .req(req), .data(data), .last(last), .ack(ack),
        .fifo_w(fifo_w), .fifo_din(fifo_din), .fifo_full(fifo_full), .fifo_clr(fifo_clr),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int total   [N];
    int sent    [N];
    int last_at [N];
    logic [7:0] fq [$];
    logic [7:0] eq [$];

    int nvec = 0;
    int nerr = 0;
    int cyc;
    logic [63:0] whist;

    logic [3:0] s_ack  [64];
    logic       s_w    [64];
    logic [7:0] s_din  [64];
    logic       s_clr  [64];
    logic       s_fd   [64];
    logic       s_busy [64];
    logic [1:0] s_own  [64];
    int         s_cnt  [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_prod();
        for (int i = 0; i < N; i++) begin
            req[i]        = (sent[i] < total[i]);
            data[i*W +: W] = 8'(8'hA0 + i*16 + sent[i]);
            last[i]       = (last_at[i] != 0) && (sent[i] + 1 == last_at[i]);
        end
    endtask

    // Sample at negedge, let the edge happen, then update fifo model and producers.
    task automatic cycle();
        int k;
        k = (cyc < 63) ? cyc : 63;
        @(negedge clk);
        s_ack[k]  = ack;
        s_w[k]    = fifo_w;
        s_din[k]  = fifo_din;
        s_clr[k]  = fifo_clr;
        s_fd[k]   = flush_done;
        s_busy[k] = busy;
        s_own[k]  = owner;
        s_cnt[k]  = fq.size();
        whist     = {whist[62:0], fifo_w};
        @(posedge clk);
        #1;
        if (s_clr[k]) fq.delete();
        else if (s_w[k]) fq.push_back(s_din[k]);
        for (int i = 0; i < N; i++) if (s_ack[k][i]) sent[i]++;
        if (s_fd[k]) flush_req = 1'b0;
        drive_prod();
        cyc++;
    endtask

    task automatic expect_words(input int i, input int from, input int n);
        for (int k = 0; k < n; k++) eq.push_back(8'(8'hA0 + i*16 + from + k));
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_len"}, 64'(fq.size()), 64'(eq.size()));
        for (int k = 0; k < eq.size(); k++)
            if (k < fq.size()) check(tag, 64'(fq[k]), 64'(eq[k]));
        eq.delete();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        fifo_full = 1'b0;
        flush_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            total[i] = 0; sent[i] = 0; last_at[i] = 0;
        end
        drive_prod();
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        fq.delete();
        cyc   = 0;
        whist = '0;
    endtask

    initial begin
        int pulses;
        rstn = 1'b0; fifo_full = 1'b0; flush_req = 1'b0;
        req = '0; data = '0; last = '0;
        for (int i = 0; i < N; i++) begin
            total[i] = 0; sent[i] = 0; last_at[i] = 0;
        end
        cyc = 0; whist = '0;
        #2;
        total[0] = 1; total[1] = 1;
        drive_prod();
        #1;
        check("rst_ack", 64'(ack), 64'h0);
        check("rst_fifo_w", 64'(fifo_w), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_owner", 64'(owner), 64'h0);
        check("rst_clr", 64'(fifo_clr), 64'h0);
        check("rst_flush_done", 64'(flush_done), 64'h0);
        check("rst_din", 64'(fifo_din), 64'hA0);

        // single requester, 6 words, last on the 6th
        do_reset();
        total[0] = 6; last_at[0] = 6;
        drive_prod();
        repeat (9) cycle();
        check("t1_wr_pattern", whist, 64'b011110110);
        expect_words(0, 0, 6);
        check_fifo("t1_fifo");
        total[0] = 7; total[1] = 1; last_at[0] = 0;
        drive_prod();
        cyc = 0; whist = '0;
        repeat (2) cycle();
        check("t1_rr_owner", 64'(s_own[1]), 64'd1);
        check("t1_rr_ack", 64'(s_ack[1]), 64'b0010);

        // all four requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) total[i] = 8;
        drive_prod();
        repeat (25) cycle();
        check("t2_wr_pattern", whist, 64'({5{5'b01111}}));
        check("t2_owner_c1", 64'(s_own[1]), 64'd0);
        check("t2_owner_c21", 64'(s_own[21]), 64'd0);
        expect_words(0, 0, 4); expect_words(1, 0, 4); expect_words(2, 0, 4);
        expect_words(3, 0, 4); expect_words(0, 4, 4);
        check_fifo("t2_fifo");

        // fifo_full for three cycles after the 2nd word of owner 2
        do_reset();
        total[2] = 6;
        drive_prod();
        for (int k = 0; k < 10; k++) begin
            fifo_full = (k >= 3 && k <= 5);
            cycle();
        end
        fifo_full = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            check("t3_full_w", 64'(s_w[k]), 64'h0);
            check("t3_full_ack", 64'(s_ack[k]), 64'h0);
            check("t3_full_owner", 64'(s_own[k]), 64'd2);
            check("t3_full_busy", 64'(s_busy[k]), 64'h1);
        end
        check("t3_wr_pattern", whist, 64'b0110001101);
        expect_words(2, 0, 5);
        check_fifo("t3_fifo");

        // requester 1 ends its burst with last on word 2, requester 3 pending
        do_reset();
        total[1] = 4; last_at[1] = 2; total[3] = 8;
        drive_prod();
        repeat (17) cycle();
        check("t4_wr_pattern", whist, 64'b01101111011001111);
        check("t4_owner_c1", 64'(s_own[1]), 64'd1);
        check("t4_owner_c4", 64'(s_own[4]), 64'd3);
        check("t4_owner_c9", 64'(s_own[9]), 64'd1);
        check("t4_owner_c13", 64'(s_own[13]), 64'd3);
        expect_words(1, 0, 2); expect_words(3, 0, 4); expect_words(1, 2, 2); expect_words(3, 4, 4);
        check_fifo("t4_fifo");

        // flush requested during the first word of a burst, requester 2 pending
        do_reset();
        total[0] = 4; total[2] = 4;
        drive_prod();
        cycle();
        flush_req = 1'b1;
        repeat (8) cycle();
        check("t5_wr_pattern", whist, 64'b011110001);
        check("t5_idle_busy", 64'(s_busy[5]), 64'h0);
        check("t5_idle_clr", 64'(s_clr[5]), 64'h0);
        check("t5_clr", 64'(s_clr[6]), 64'h1);
        check("t5_flush_done", 64'(s_fd[6]), 64'h1);
        check("t5_flush_busy", 64'(s_busy[6]), 64'h1);
        check("t5_fifo_before_clr", 64'(s_cnt[6]), 64'd4);
        check("t5_fifo_empty", 64'(s_cnt[7]), 64'd0);
        check("t5_done_low", 64'(s_fd[7]), 64'h0);
        check("t5_owner", 64'(s_own[8]), 64'd2);
        check("t5_ack", 64'(s_ack[8]), 64'b0100);
        pulses = 0;
        for (int k = 0; k < 9; k++) if (s_fd[k]) pulses++;
        check("t5_pulses", 64'(pulses), 64'd1);

        // asynchronous reset in the middle of a burst
        do_reset();
        total[0] = 8;
        drive_prod();
        cycle();
        cycle();
        #2;
        check("t6_pre_w", 64'(fifo_w), 64'h1);
        rstn = 1'b0;
        #1;
        check("t6_rst_w", 64'(fifo_w), 64'h0);
        check("t6_rst_ack", 64'(ack), 64'h0);
        check("t6_rst_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            total[i] = 0; sent[i] = 0;
        end
        total[1] = 4; total[3] = 4;
        drive_prod();
        #2 rstn = 1'b1;
        cyc = 0; whist = '0;
        repeat (2) cycle();
        check("t6_arb_busy", 64'(s_busy[0]), 64'h0);
        check("t6_arb_w", 64'(s_w[0]), 64'h0);
        check("t6_owner", 64'(s_own[1]), 64'd1);
        check("t6_ack", 64'(s_ack[1]), 64'b0010);
        check("t6_din", 64'(s_din[1]), 64'hB0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
